// File: rtl/spi_jtag_pkg.sv
// Shared definitions for the SPI-over-JTAG framer: FSM encoding, start marker
// and the default width of the payload length field.
package spi_jtag_pkg;

  localparam int   LEN_WIDTH_DEF = 16;
  localparam logic START_MARKER  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HUNT = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/spi_jtag_framer.sv
// Frames virtual-JTAG Shift-DR bits as start marker + length + payload and drives
// the SPI flash pins only for the payload; flash output is returned on tdo.
module spi_jtag_framer
  import spi_jtag_pkg::*;
#(
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic tck,
  input  logic rst_n,
  input  logic vs_cdr,
  input  logic vs_sdr,
  input  logic tdi,
  input  logic spi_so,
  output logic tdo,
  output logic spi_csn,
  output logic spi_si,
  output logic spi_clk_en,
  output logic busy,
  output logic trunc_err
);

  localparam int CW = (LEN_WIDTH > 1) ? $clog2(LEN_WIDTH) : 1;
  localparam logic [CW-1:0] LEN_LAST = CW'(LEN_WIDTH - 1);

  // Handshake: there is none; vs_sdr qualifies every tdi bit on the rising tck edge.
  state_e               state_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] len_d;
  logic [LEN_WIDTH-1:0] rem_q;
  logic [CW-1:0]        cnt_q;
  logic                 tdo_q;
  logic                 csn_q;
  logic                 si_q;
  logic                 clk_en_q;
  logic                 trunc_q;

  // Length arrives LSB first, so each new bit enters at the top.
  always_comb begin
    len_d = {tdi, len_q[LEN_WIDTH-1:1]};
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      tdo_q    <= 1'b0;
      csn_q    <= 1'b1;
      si_q     <= 1'b0;
      clk_en_q <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      // Flash data is only meaningful while the registered chip select is low.
      tdo_q <= csn_q ? tdi : spi_so;

      if (!vs_sdr && (state_q == ST_DATA)) begin
        trunc_q <= 1'b1;
      end else if (vs_cdr) begin
        trunc_q <= 1'b0;
      end

      if (!vs_sdr) begin
        state_q  <= ST_IDLE;
        csn_q    <= 1'b1;
        clk_en_q <= 1'b0;
        cnt_q    <= '0;
        rem_q    <= '0;
      end else begin
        csn_q    <= 1'b1;
        clk_en_q <= 1'b0;
        unique case (state_q)
          ST_IDLE, ST_HUNT: begin
            if (tdi == START_MARKER) begin
              state_q <= ST_LEN;
              cnt_q   <= '0;
            end else begin
              state_q <= ST_HUNT;
            end
          end
          ST_LEN: begin
            len_q <= len_d;
            if (cnt_q == LEN_LAST) begin
              cnt_q <= '0;
              if (len_d != '0) begin
                state_q <= ST_DATA;
                rem_q   <= len_d;
              end else begin
                state_q <= ST_DONE;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          ST_DATA: begin
            si_q     <= tdi;
            csn_q    <= 1'b0;
            clk_en_q <= 1'b1;
            if (rem_q != '0) begin
              rem_q <= rem_q - LEN_WIDTH'(1);
            end
            if (rem_q <= LEN_WIDTH'(1)) begin
              state_q <= ST_DONE;
            end
          end
          ST_DONE: begin
            state_q <= ST_DONE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign tdo        = tdo_q;
  assign spi_csn    = csn_q;
  assign spi_si     = si_q;
  assign spi_clk_en = clk_en_q;
  assign busy       = (state_q == ST_LEN) || (state_q == ST_DATA);
  assign trunc_err  = trunc_q;

endmodule
